// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: client-side and bus-side AXI read signals for the arbiter.
// Ports: c_ar*/c_r* per-client channels, m_ar*/m_r* bus port, busy, rid_err.
interface axi_rd_arbiter_if #(
   parameter int CLIENT_NUM = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4
);
   localparam int CIDX_WIDTH =
      (CLIENT_NUM > 1) ? $clog2(CLIENT_NUM) : 1;
   localparam int M_ID_WIDTH = ID_WIDTH + CIDX_WIDTH;

   logic [CLIENT_NUM-1:0]            c_arvalid;
   logic [CLIENT_NUM-1:0]            c_arready;
   logic [CLIENT_NUM*ADDR_WIDTH-1:0] c_araddr;
   logic [CLIENT_NUM*ID_WIDTH-1:0]   c_arid;
   logic [CLIENT_NUM*8-1:0]          c_arlen;
   logic [CLIENT_NUM*3-1:0]          c_arsize;
   logic [CLIENT_NUM*2-1:0]          c_arburst;
   logic [CLIENT_NUM-1:0]            c_rvalid;
   logic [CLIENT_NUM-1:0]            c_rready;
   logic [DATA_WIDTH-1:0]            c_rdata;
   logic [ID_WIDTH-1:0]              c_rid;
   logic [1:0]                       c_rresp;
   logic                             c_rlast;

   logic                             m_arvalid;
   logic                             m_arready;
   logic [ADDR_WIDTH-1:0]            m_araddr;
   logic [M_ID_WIDTH-1:0]            m_arid;
   logic [7:0]                       m_arlen;
   logic [2:0]                       m_arsize;
   logic [1:0]                       m_arburst;
   logic                             m_rvalid;
   logic                             m_rready;
   logic [DATA_WIDTH-1:0]            m_rdata;
   logic [M_ID_WIDTH-1:0]            m_rid;
   logic [1:0]                       m_rresp;
   logic                             m_rlast;

   logic [CLIENT_NUM-1:0]            busy;
   logic                             rid_err;

   // slave: the arbiter itself
   modport slave (
      input  c_arvalid, c_araddr, c_arid, c_arlen, c_arsize, c_arburst,
      output c_arready,
      output c_rvalid, c_rdata, c_rid, c_rresp, c_rlast,
      input  c_rready,
      output m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst,
      input  m_arready,
      input  m_rvalid, m_rdata, m_rid, m_rresp, m_rlast,
      output m_rready,
      output busy, rid_err
   );

   // master: clients plus bus, as seen from the surroundings
   modport master (
      output c_arvalid, c_araddr, c_arid, c_arlen, c_arsize, c_arburst,
      input  c_arready,
      input  c_rvalid, c_rdata, c_rid, c_rresp, c_rlast,
      output c_rready,
      input  m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst,
      output m_arready,
      output m_rvalid, m_rdata, m_rid, m_rresp, m_rlast,
      input  m_rready,
      input  busy, rid_err
   );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: N-client AXI read arbiter, round-robin AR, R routed by ID tag.
// Ports: clk, rst (async high), bus (axi_rd_arbiter_if.slave).
// Option: AXI_RD_PRIO_EN gives client 0 strict priority over round-robin.
module axi_rd_arbiter #(
   parameter int CLIENT_NUM      = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 64,
   parameter int ID_WIDTH        = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rst,
   axi_rd_arbiter_if.slave   bus
);
   localparam int CIDX_WIDTH =
      (CLIENT_NUM > 1) ? $clog2(CLIENT_NUM) : 1;
   localparam int M_ID_WIDTH = ID_WIDTH + CIDX_WIDTH;
   localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

   logic                  slot_valid_q, slot_valid_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [M_ID_WIDTH-1:0] id_q, id_d;
   logic [7:0]            len_q, len_d;
   logic [2:0]            size_q, size_d;
   logic [1:0]            burst_q, burst_d;
   logic [CIDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [3:0]            cnt_q [CLIENT_NUM];
   logic [3:0]            cnt_d [CLIENT_NUM];
   logic                  rid_err_q;

   logic [CLIENT_NUM-1:0] elig;
   logic [CIDX_WIDTH-1:0] gnt_idx;
   logic                  gnt_found;
   logic                  slot_free;
   logic                  gnt;
   int                    idx;
   logic [CIDX_WIDTH-1:0] sel;
   logic                  sel_ok;
   logic                  r_done;
   logic [CLIENT_NUM-1:0] rvalid;
   logic                  rready;
   logic [CLIENT_NUM-1:0] busy;

   assign slot_free = !slot_valid_q || bus.m_arready;
   assign gnt       = slot_free && gnt_found;

   always_comb begin
      for (int i = 0; i < CLIENT_NUM; i++)
         elig[i] = bus.c_arvalid[i] && (cnt_q[i] < MAX_CNT);
   end

   // Scan from rr_ptr upward with wrap; first eligible wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
`ifdef AXI_RD_PRIO_EN
      if (elig[0])
         gnt_found = 1'b1;
`endif
      for (int k = 0; k < CLIENT_NUM; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= CLIENT_NUM)
            idx = idx - CLIENT_NUM;
`ifdef AXI_RD_PRIO_EN
         if (!gnt_found && idx != 0 && elig[idx]) begin
`else
         if (!gnt_found && elig[idx]) begin
`endif
            gnt_found = 1'b1;
            gnt_idx   = CIDX_WIDTH'(idx);
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt) begin
         if (int'(gnt_idx) == CLIENT_NUM - 1)
            rr_ptr_d = '0;
         else
            rr_ptr_d = gnt_idx + CIDX_WIDTH'(1);
      end
`ifdef AXI_RD_PRIO_EN
      // Priority wins leave the rotation among the others untouched.
      if (gnt && gnt_idx == '0)
         rr_ptr_d = rr_ptr_q;
`endif
   end

   assign bus.c_arready =
      gnt ? (CLIENT_NUM'(1) << gnt_idx) : '0;

   always_comb begin
      slot_valid_d = slot_valid_q;
      addr_d       = addr_q;
      id_d         = id_q;
      len_d        = len_q;
      size_d       = size_q;
      burst_d      = burst_q;
      if (slot_free) begin
         slot_valid_d = gnt;
         if (gnt) begin
            addr_d  = bus.c_araddr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            id_d    = {gnt_idx,
                       bus.c_arid[int'(gnt_idx)*ID_WIDTH +: ID_WIDTH]};
            len_d   = bus.c_arlen[int'(gnt_idx)*8 +: 8];
            size_d  = bus.c_arsize[int'(gnt_idx)*3 +: 3];
            burst_d = bus.c_arburst[int'(gnt_idx)*2 +: 2];
         end
      end
   end

   assign bus.m_arvalid = slot_valid_q;
   assign bus.m_araddr  = addr_q;
   assign bus.m_arid    = id_q;
   assign bus.m_arlen   = len_q;
   assign bus.m_arsize  = size_q;
   assign bus.m_arburst = burst_q;

   // R path: route each beat by its tag; unknown tags are swallowed.
   assign sel    = bus.m_rid[M_ID_WIDTH-1:ID_WIDTH];
   assign sel_ok = int'(sel) < CLIENT_NUM;

   always_comb begin
      rvalid = '0;
      rready = 1'b1;
      if (sel_ok) begin
         rvalid[sel] = bus.m_rvalid;
         rready      = bus.c_rready[sel];
      end
   end

   assign bus.c_rvalid = rvalid;
   assign bus.m_rready = rready;
   assign bus.c_rdata  = DATA_WIDTH'(bus.m_rdata);
   assign bus.c_rid    = bus.m_rid[ID_WIDTH-1:0];
   assign bus.c_rresp  = bus.m_rresp;
   assign bus.c_rlast  = bus.m_rlast;

   assign r_done = bus.m_rvalid && rready && bus.m_rlast && sel_ok;

   // An rlast against an empty counter is ignored rather than wrapping.
   always_comb begin
      for (int i = 0; i < CLIENT_NUM; i++) begin
         cnt_d[i] = cnt_q[i];
         busy[i]  = cnt_q[i] != 4'd0;
         if ((gnt && int'(gnt_idx) == i) &&
             !(r_done && int'(sel) == i && cnt_q[i] != 4'd0))
            cnt_d[i] = cnt_q[i] + 4'd1;
         else if (!(gnt && int'(gnt_idx) == i) &&
                  (r_done && int'(sel) == i && cnt_q[i] != 4'd0))
            cnt_d[i] = cnt_q[i] - 4'd1;
      end
   end

   assign bus.busy    = busy;
   assign bus.rid_err = rid_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_valid_q <= 1'b0;
         addr_q       <= '0;
         id_q         <= '0;
         len_q        <= '0;
         size_q       <= '0;
         burst_q      <= '0;
         rr_ptr_q     <= '0;
         rid_err_q    <= 1'b0;
         for (int i = 0; i < CLIENT_NUM; i++)
            cnt_q[i] <= '0;
      end else begin
         slot_valid_q <= slot_valid_d;
         addr_q       <= addr_d;
         id_q         <= id_d;
         len_q        <= len_d;
         size_q       <= size_d;
         burst_q      <= burst_d;
         rr_ptr_q     <= rr_ptr_d;
         if (bus.m_rvalid && !sel_ok)
            rid_err_q <= 1'b1;
         for (int i = 0; i < CLIENT_NUM; i++)
            cnt_q[i] <= cnt_d[i];
      end
   end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed checks of AR arbitration, R routing and limits.
// Two instances: 2 clients (limit 2) and 3 clients (limit 4).
module tb_axi_rd_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   axi_rd_arbiter_if #(
      .CLIENT_NUM(2), .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)
   ) ia ();
   axi_rd_arbiter_if #(
      .CLIENT_NUM(3), .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)
   ) ib ();

   axi_rd_arbiter #(
      .CLIENT_NUM(2), .ADDR_WIDTH(32), .DATA_WIDTH(64),
      .ID_WIDTH(4), .MAX_OUTSTANDING(2)
   ) ua (.clk(clk), .rst(rst), .bus(ia));

   axi_rd_arbiter #(
      .CLIENT_NUM(3), .ADDR_WIDTH(32), .DATA_WIDTH(64),
      .ID_WIDTH(4), .MAX_OUTSTANDING(4)
   ) ub (.clk(clk), .rst(rst), .bus(ib));

   logic [1:0] rr_rdy [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
   logic [4:0] rr_id  [5] = '{5'h00, 5'h03, 5'h15, 5'h03, 5'h15};
   logic [2:0] rb_rdy [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
   logic [5:0] rb_id  [4] = '{6'h00, 6'h01, 6'h12, 6'h23};

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic rst_apply();
      rst = 1'b1;
      ia.c_arvalid = '0; ia.c_araddr = '0; ia.c_arid = '0;
      ia.c_arlen = '0; ia.c_arsize = '0; ia.c_arburst = '0;
      ia.c_rready = '0; ia.m_arready = 1'b0; ia.m_rvalid = 1'b0;
      ia.m_rdata = '0; ia.m_rid = '0; ia.m_rresp = '0;
      ia.m_rlast = 1'b0;
      ib.c_arvalid = '0; ib.c_araddr = '0; ib.c_arid = '0;
      ib.c_arlen = '0; ib.c_arsize = '0; ib.c_arburst = '0;
      ib.c_rready = '0; ib.m_arready = 1'b0; ib.m_rvalid = 1'b0;
      ib.m_rdata = '0; ib.m_rid = '0; ib.m_rresp = '0;
      ib.m_rlast = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst_apply();
      chk("rst_arvalid", ia.m_arvalid, 0);
      chk("rst_araddr", ia.m_araddr, 0);
      chk("rst_busy", ia.busy, 0);
      chk("rst_riderr", ib.rid_err, 0);
      rst = 1'b0;

      // Round-robin, one AR per cycle
      @(negedge clk);
      ia.c_araddr  = {32'h2000, 32'h1000};
      ia.c_arid    = {4'h5, 4'h3};
      ia.c_arvalid = 2'b11;
      ia.m_arready = 1'b1;
      #1;
      chk("rr_rdy0", ia.c_arready, rr_rdy[0]);
      chk("rr_arv0", ia.m_arvalid, 0);
      for (int c = 1; c < 5; c++) begin
         @(negedge clk);
         #1;
         chk("rr_rdy", ia.c_arready, rr_rdy[c]);
         chk("rr_arid", ia.m_arid, rr_id[c]);
         chk("rr_arv", ia.m_arvalid, 1);
      end
      chk("rr_busy", ia.busy, 2'b11);
      ia.c_arvalid = '0;
      @(negedge clk);
      #1;
      chk("rr_drain", ia.m_arvalid, 0);

      // Client 1 burst of 4 beats
      rst_apply();
      rst = 1'b0;
      @(negedge clk);
      ia.c_araddr  = {32'h40, 32'h0};
      ia.c_arid    = {4'h5, 4'h0};
      ia.c_arlen   = {8'd3, 8'd0};
      ia.c_arsize  = {3'd3, 3'd0};
      ia.c_arburst = {2'b01, 2'b00};
      ia.c_arvalid = 2'b10;
      ia.m_arready = 1'b1;
      #1;
      chk("b_rdy", ia.c_arready, 2'b10);
      @(negedge clk);
      ia.c_arvalid = '0;
      #1;
      chk("b_arv", ia.m_arvalid, 1);
      chk("b_addr", ia.m_araddr, 32'h40);
      chk("b_arid", ia.m_arid, 5'h15);
      chk("b_len", ia.m_arlen, 3);
      chk("b_size", ia.m_arsize, 3);
      chk("b_burst", ia.m_arburst, 1);
      chk("b_busy1", ia.busy, 2'b10);
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         ia.m_rvalid = 1'b1;
         ia.m_rid    = 5'h15;
         ia.m_rdata  = 64'hA0 + 64'(b);
         ia.m_rlast  = (b == 3);
         ia.c_rready = 2'b11;
         #1;
         chk("r_valid", ia.c_rvalid, 2'b10);
         chk("r_id", ia.c_rid, 4'h5);
         chk("r_data", ia.c_rdata, 64'hA0 + 64'(b));
         chk("r_last", ia.c_rlast, (b == 3));
         chk("r_mrdy", ia.m_rready, 1);
         chk("r_busy", ia.busy, 2'b10);
      end
      @(negedge clk);
      ia.m_rvalid = 1'b0;
      ia.m_rlast  = 1'b0;
      #1;
      chk("b_busy0", ia.busy, 2'b00);
      chk("b_idle", ia.c_rvalid, 2'b00);
      @(negedge clk);
      ia.m_rvalid = 1'b1;
      ia.c_rready = 2'b01;
      #1;
      chk("r_bp", ia.m_rready, 0);
      chk("r_bpv", ia.c_rvalid, 2'b10);
      @(negedge clk);
      ia.m_rvalid = 1'b0;

      // Outstanding limit of 2
      rst_apply();
      rst = 1'b0;
      @(negedge clk);
      ia.c_arid    = {4'h0, 4'h2};
      ia.c_arvalid = 2'b01;
      ia.m_arready = 1'b1;
      #1;
      chk("lim_g1", ia.c_arready, 2'b01);
      @(negedge clk);
      #1;
      chk("lim_g2", ia.c_arready, 2'b01);
      @(negedge clk);
      #1;
      chk("lim_blk1", ia.c_arready, 2'b00);
      @(negedge clk);
      #1;
      chk("lim_blk2", ia.c_arready, 2'b00);
      chk("lim_busy", ia.busy, 2'b01);
      @(negedge clk);
      ia.m_rvalid = 1'b1;
      ia.m_rid    = 5'h02;
      ia.m_rlast  = 1'b1;
      ia.c_rready = 2'b01;
      #1;
      chk("lim_blk3", ia.c_arready, 2'b00);
      @(negedge clk);
      ia.m_rvalid = 1'b0;
      #1;
      chk("lim_g3", ia.c_arready, 2'b01);
      @(negedge clk);
      ia.c_arvalid = '0;

      // Same-cycle grant and rlast on client 0
      rst_apply();
      rst = 1'b0;
      @(negedge clk);
      ia.c_arid    = {4'h0, 4'h2};
      ia.c_arvalid = 2'b01;
      ia.m_arready = 1'b1;
      #1;
      chk("sc_g1", ia.c_arready, 2'b01);
      @(negedge clk);
      ia.m_rvalid = 1'b1;
      ia.m_rid    = 5'h02;
      ia.m_rlast  = 1'b1;
      ia.c_rready = 2'b01;
      #1;
      chk("sc_g2", ia.c_arready, 2'b01);
      @(negedge clk);
      ia.m_rvalid  = 1'b0;
      ia.c_arvalid = '0;
      #1;
      chk("sc_busy1", ia.busy, 2'b01);
      @(negedge clk);
      ia.m_rvalid = 1'b1;
      @(negedge clk);
      ia.m_rvalid = 1'b0;
      #1;
      chk("sc_busy0", ia.busy, 2'b00);

      // Stall with slot loaded
      rst_apply();
      rst = 1'b0;
      @(negedge clk);
      ia.c_araddr  = {32'h0, 32'h100};
      ia.c_arid    = {4'h0, 4'h1};
      ia.c_arvalid = 2'b01;
      ia.m_arready = 1'b0;
      #1;
      chk("st_g", ia.c_arready, 2'b01);
      @(negedge clk);
      ia.c_araddr  = {32'h300, 32'h200};
      ia.c_arid    = {4'h6, 4'h2};
      ia.c_arvalid = 2'b11;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk("st_rdy", ia.c_arready, 2'b00);
         chk("st_addr", ia.m_araddr, 32'h100);
         chk("st_arid", ia.m_arid, 5'h01);
         chk("st_arv", ia.m_arvalid, 1);
         @(negedge clk);
      end
      ia.m_arready = 1'b1;
      #1;
      chk("st_resume", ia.c_arready, 2'b10);
      @(negedge clk);
      ia.c_arvalid = '0;
      #1;
      chk("st_addr2", ia.m_araddr, 32'h300);
      chk("st_arid2", ia.m_arid, 5'h16);

      // Three clients: rotation, routing, bad tag
      rst_apply();
      rst = 1'b0;
      @(negedge clk);
      ib.c_arid    = {4'h3, 4'h2, 4'h1};
      ib.c_arvalid = 3'b111;
      ib.m_arready = 1'b1;
      #1;
      chk("r3_rdy0", ib.c_arready, rb_rdy[0]);
      for (int c = 1; c < 4; c++) begin
         @(negedge clk);
         #1;
         chk("r3_rdy", ib.c_arready, rb_rdy[c]);
         chk("r3_arid", ib.m_arid, rb_id[c]);
      end
      @(negedge clk);
      ib.c_arvalid = '0;
      ib.m_rvalid  = 1'b1;
      ib.m_rid     = 6'h21;
      ib.c_rready  = 3'b100;
      #1;
      chk("r3_route", ib.c_rvalid, 3'b100);
      chk("r3_rid", ib.c_rid, 4'h1);
      @(negedge clk);
      ib.m_rid    = 6'h37;
      ib.c_rready = 3'b000;
      #1;
      chk("bad_mrdy", ib.m_rready, 1);
      chk("bad_rv", ib.c_rvalid, 3'b000);
      chk("bad_pre", ib.rid_err, 0);
      @(negedge clk);
      ib.m_rvalid = 1'b0;
      #1;
      chk("bad_set", ib.rid_err, 1);
      @(negedge clk);
      #1;
      chk("bad_hold", ib.rid_err, 1);
      rst_apply();
      chk("bad_clr", ib.rid_err, 0);
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
